// File: rtl/key_state_tracker.sv
// Tracks held state of four game keys, resolves left/right movement and paces auto-fire by video frame.
// All outputs registered; key changes reach held after one edge, commands after two.
module key_state_tracker #(
  parameter logic [8:0]  KEY_LEFT             = 9'h06B,
  parameter logic [8:0]  KEY_RIGHT            = 9'h074,
  parameter logic [8:0]  KEY_FIRE             = 9'h029,
  parameter logic [8:0]  KEY_PAUSE            = 9'h04D,
  parameter int unsigned FIRE_COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [8:0] keyCode,
  input  logic       make,
  input  logic       brake,
  input  logic       startOfFrame,
  output logic [3:0] held,
  output logic       move_left,
  output logic       move_right,
  output logic       fire_pulse,
  output logic       pause_toggle
);

  typedef enum logic {READY, COOLDOWN} fire_state_t;
  typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;

  localparam logic [7:0] COOLDOWN_LOAD = 8'(FIRE_COOLDOWN_FRAMES);

  // Bit order matches held: {pause, fire, right, left}
  logic [3:0]  key_hit;
  logic [3:0]  held_nxt;
  dir_t        last_dir;
  dir_t        last_dir_nxt;
  logic        move_left_nxt;
  logic        move_right_nxt;
  logic        pause_nxt;

  fire_state_t fire_state;
  fire_state_t fire_state_nxt;
  logic [7:0]  cool_cnt;
  logic [7:0]  cool_cnt_nxt;
  logic        fire_nxt;

  assign key_hit = {keyCode == KEY_PAUSE, keyCode == KEY_FIRE,
                    keyCode == KEY_RIGHT, keyCode == KEY_LEFT};

  always_comb begin
    held_nxt = held;
    if (brake) begin
      held_nxt = held & ~key_hit;
    end else if (make) begin
      held_nxt = held | key_hit;
    end
  end

  always_comb begin
    last_dir_nxt = last_dir;
    if (make && key_hit[0]) begin
      last_dir_nxt = DIR_LEFT;
    end else if (make && key_hit[1]) begin
      last_dir_nxt = DIR_RIGHT;
    end
  end

  // With both directions held, the most recently pressed one wins.
  always_comb begin
    move_left_nxt  = enable & held[0] & (~held[1] | (last_dir == DIR_LEFT));
    move_right_nxt = enable & held[1] & (~held[0] | (last_dir == DIR_RIGHT));
  end

  // Repeat makes arrive with held_pause already set and are ignored.
  assign pause_nxt = make & key_hit[3] & ~held[3];

  always_comb begin
    fire_state_nxt = fire_state;
    cool_cnt_nxt   = cool_cnt;
    fire_nxt       = 1'b0;
    if (!enable) begin
      fire_state_nxt = READY;
      cool_cnt_nxt   = 8'd0;
    end else begin
      case (fire_state)
        READY: begin
          if (held[2]) begin
            fire_nxt       = 1'b1;
            cool_cnt_nxt   = COOLDOWN_LOAD;
            fire_state_nxt = COOLDOWN;
          end
        end
        COOLDOWN: begin
          // Counter keeps running even if fire is released mid-cooldown.
          if (startOfFrame) begin
            if (cool_cnt <= 8'd1) begin
              cool_cnt_nxt   = 8'd0;
              fire_state_nxt = READY;
            end else begin
              cool_cnt_nxt = cool_cnt - 8'd1;
            end
          end
        end
        default: begin
          fire_state_nxt = READY;
          cool_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held         <= 4'b0000;
      last_dir     <= DIR_LEFT;
      move_left    <= 1'b0;
      move_right   <= 1'b0;
      pause_toggle <= 1'b0;
      fire_state   <= READY;
      cool_cnt     <= 8'd0;
      fire_pulse   <= 1'b0;
    end else begin
      held         <= held_nxt;
      last_dir     <= last_dir_nxt;
      move_left    <= move_left_nxt;
      move_right   <= move_right_nxt;
      pause_toggle <= pause_nxt;
      fire_state   <= fire_state_nxt;
      cool_cnt     <= cool_cnt_nxt;
      fire_pulse   <= fire_nxt;
    end
  end

endmodule

// File: doc/key_state_tracker.md
KEY_STATE_TRACKER -- requirements
Module: key_state_tracker

Interface
REQ-001 Parameter KEY_LEFT, default 9'h06B, keycode of the move-left key.
REQ-002 Parameter KEY_RIGHT, default 9'h074, keycode of the move-right key.
REQ-003 Parameter KEY_FIRE, default 9'h029, keycode of the fire key.
REQ-004 Parameter KEY_PAUSE, default 9'h04D, keycode of the pause key.
REQ-005 Parameter FIRE_COOLDOWN_FRAMES, default 8, frames between auto-fire shots; legal range 1..255.
REQ-006 clk  input  1  system clock; the block uses one clock only.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 enable  input  1  game-play enable; low gates all action outputs.
REQ-009 keyCode  input  9  keycode from the keyboard interface; bit 8 is the extended-code flag.
REQ-010 make  input  1  one-cycle pulse: keyCode was pressed, including typematic repeats.
REQ-011 brake  input  1  one-cycle pulse: keyCode was released.
REQ-012 startOfFrame  input  1  one-cycle pulse once per video frame.
REQ-013 held  output  4  registered key-held bitmap {pause, fire, right, left}.
REQ-014 move_left  output  1  registered, resolved left-move command.
REQ-015 move_right  output  1  registered, resolved right-move command.
REQ-016 fire_pulse  output  1  registered one-cycle shot request.
REQ-017 pause_toggle  output  1  registered one-cycle pulse on a fresh pause press.

Function
REQ-018 On a make whose keyCode matches a key parameter, the matching held bit SHALL be 1 from the next clock edge (latency 1).
REQ-019 On a brake matching a key, the held bit SHALL be 0 from the next edge.
REQ-020 If make and brake are asserted together, brake SHALL win and the held bit is cleared.
REQ-021 A keyCode matching no parameter SHALL change no state; keyCode is ignored when make and brake are both 0.
REQ-022 A make of KEY_LEFT SHALL set last_dir=LEFT; a make of KEY_RIGHT SHALL set last_dir=RIGHT. last_dir is internal and resets to LEFT.
REQ-023 move_left SHALL be enable & held_left & (~held_right | last_dir==LEFT), registered, using held values from the previous cycle.
REQ-024 move_right SHALL be enable & held_right & (~held_left | last_dir==RIGHT), registered.
REQ-025 move_left and move_right SHALL never be 1 in the same cycle.
REQ-026 When the last-pressed direction key is released while the other is still held, the other direction SHALL take over on the following cycle.
REQ-027 The fire FSM SHALL have two states, READY and COOLDOWN, plus an 8-bit frame counter.
- READY with enable & held_fire: assert fire_pulse for one cycle, load counter = FIRE_COOLDOWN_FRAMES, go to COOLDOWN.
- COOLDOWN: decrement the counter on each startOfFrame; when the counter is 1 and startOfFrame arrives, go to READY.
REQ-028 A held fire key SHALL therefore auto-fire once every FIRE_COOLDOWN_FRAMES frames. Typematic repeat makes SHALL NOT cause extra shots.
REQ-029 Latency from a fire make to fire_pulse in READY SHALL be 2 cycles.
REQ-030 If the fire key is released during COOLDOWN, the counter SHALL keep running. A new press before expiry SHALL NOT shoot until READY.
REQ-031 enable low SHALL force move_left, move_right and fire_pulse to 0 and force the FSM to READY with counter 0. held and last_dir SHALL keep tracking.
REQ-032 pause_toggle SHALL pulse one cycle after a KEY_PAUSE make only if held_pause was 0, so typematic repeats are ignored. It is independent of enable.

Reset
REQ-033 While rst is high, held=0, move_left=0, move_right=0, fire_pulse=0, pause_toggle=0, FSM=READY, counter=0 and last_dir=LEFT, all asynchronously.
REQ-034 Deasserting rst mid-cooldown or with keys physically held SHALL resume from the reset state. Keys count as released until a new make arrives.

Verification
REQ-035 Bench SHALL cover: enable=1, make KEY_LEFT at cycle 0 -> held=4'b0001 at cycle 1, move_left=1 at cycle 2, move_right=0.
REQ-036 Bench SHALL cover: LEFT held, then make KEY_RIGHT -> move_right=1, move_left=0; then brake KEY_RIGHT -> move_left=1 the next cycle after held updates.
REQ-037 Bench SHALL cover: FIRE_COOLDOWN_FRAMES=3, fire held for 10 frames with a typematic make every 2 frames -> fire_pulse on the first shot and then exactly every 3rd startOfFrame, 4 pulses in total.
REQ-038 Bench SHALL cover: make and brake of KEY_FIRE in the same cycle -> held_fire=0 and no fire_pulse.
REQ-039 Bench SHALL cover: enable=0 with fire held -> no fire_pulse. Raise enable -> fire_pulse 1 cycle later.
REQ-040 Bench SHALL cover: KEY_PAUSE make, a repeat make, then brake and make again -> exactly 2 pause_toggle pulses. rst mid-cooldown -> all outputs 0 and the next fire make shoots with 2-cycle latency.
